// File: rtl/alu_req_arbiter_if.sv
// ALU-side bus of the request arbiter: the arbiter is the only master,
// the ALU answers with done/result one cycle after start.
interface alu_req_arbiter_if;
   logic        alu_start;
   logic [7:0]  alu_a;
   logic [7:0]  alu_b;
   logic [2:0]  alu_op;
   logic        alu_done;
   logic [15:0] alu_result;

   modport master (
      output alu_start, alu_a, alu_b, alu_op,
      input  alu_done, alu_result
   );

   modport slave (
      input  alu_start, alu_a, alu_b, alu_op,
      output alu_done, alu_result
   );
endinterface

// File: rtl/alu_req_arbiter.sv
// Round-robin arbiter that shares one ALU among NUM_REQ requesters, issuing
// one operation at a time and returning the result (or a timeout error).
module alu_req_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int TIMEOUT = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NUM_REQ-1:0]     req,
   input  logic [8*NUM_REQ-1:0]   req_a,
   input  logic [8*NUM_REQ-1:0]   req_b,
   input  logic [3*NUM_REQ-1:0]   req_op,
   output logic [NUM_REQ-1:0]     gnt,
   output logic [NUM_REQ-1:0]     rsp_valid,
   output logic [15:0]            rsp_result,
   output logic                   rsp_err,
   output logic                   busy,
   alu_req_arbiter_if.master      alu
);

   localparam int IDXW = $clog2(NUM_REQ);
   localparam int CNTW = $clog2(TIMEOUT + 1);
   localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t          state;
   logic [IDXW-1:0] ptr;
   logic [IDXW-1:0] idx;
   logic [2:0]      op_latch;
   logic [CNTW-1:0] count;

   logic            win_found;
   logic [IDXW-1:0] win_idx;
   logic [IDXW-1:0] cand;
   logic [7:0]      win_a;
   logic [7:0]      win_b;
   logic [2:0]      win_op;

   // First requesting index at or after ptr, wrapping modulo NUM_REQ.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         cand = IDXW'((int'(ptr) + i) % NUM_REQ);
         if (!win_found && req[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
   end

   always_comb begin
      win_a  = '0;
      win_b  = '0;
      win_op = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (win_idx == IDXW'(i)) begin
            win_a  = req_a[8*i +: 8];
            win_b  = req_b[8*i +: 8];
            win_op = req_op[3*i +: 3];
         end
      end
   end

   // Outputs are registered one state early so they are valid during the named state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= IDLE;
         ptr            <= '0;
         idx            <= '0;
         op_latch       <= '0;
         count          <= '0;
         gnt            <= '0;
         rsp_valid      <= '0;
         rsp_result     <= '0;
         rsp_err        <= 1'b0;
         busy           <= 1'b0;
         alu.alu_start  <= 1'b0;
         alu.alu_a      <= '0;
         alu.alu_b      <= '0;
         alu.alu_op     <= '0;
      end else begin
         gnt           <= '0;
         rsp_valid     <= '0;
         rsp_result    <= '0;
         rsp_err       <= 1'b0;
         alu.alu_start <= 1'b0;
         unique case (state)
            IDLE: begin
               if (win_found) begin
                  idx      <= win_idx;
                  op_latch <= win_op;
                  gnt      <= ONE_HOT0 << win_idx;
                  busy     <= 1'b1;
                  if (win_op != 3'd0) begin
                     alu.alu_start <= 1'b1;
                     alu.alu_a     <= win_a;
                     alu.alu_b     <= win_b;
                     alu.alu_op    <= win_op;
                  end
                  state <= ISSUE;
               end
            end
            ISSUE: begin
               if (op_latch != 3'd0) begin
                  count <= '0;
                  state <= WAIT;
               end else begin
                  rsp_valid <= ONE_HOT0 << idx;
                  rsp_err   <= 1'b1;
                  state     <= RESP;
               end
            end
            WAIT: begin
               count <= count + 1'b1;
               if (alu.alu_done) begin
                  rsp_valid  <= ONE_HOT0 << idx;
                  rsp_result <= alu.alu_result;
                  state      <= RESP;
               end else if (count == CNTW'(TIMEOUT - 1)) begin
                  // This is the TIMEOUT-th WAIT cycle without done.
                  rsp_valid <= ONE_HOT0 << idx;
                  rsp_err   <= 1'b1;
                  state     <= RESP;
               end
            end
            RESP: begin
               ptr   <= (idx == IDXW'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Randomized bench for alu_req_arbiter: a transaction-level model predicts the
// winner, latency and response of each accepted request.
module tb_alu_req_arbiter;

   localparam int NUM_REQ = 4;
   localparam int TIMEOUT = 8;

   logic                 clk = 1'b0;
   logic                 rst;
   logic [NUM_REQ-1:0]   req;
   logic [8*NUM_REQ-1:0] req_a;
   logic [8*NUM_REQ-1:0] req_b;
   logic [3*NUM_REQ-1:0] req_op;
   logic [NUM_REQ-1:0]   gnt;
   logic [NUM_REQ-1:0]   rsp_valid;
   logic [15:0]          rsp_result;
   logic                 rsp_err;
   logic                 busy;

   alu_req_arbiter_if alu_bus ();

   alu_req_arbiter #(.NUM_REQ(NUM_REQ), .TIMEOUT(TIMEOUT)) dut (
      .clk        (clk),
      .rst        (rst),
      .req        (req),
      .req_a      (req_a),
      .req_b      (req_b),
      .req_op     (req_op),
      .gnt        (gnt),
      .rsp_valid  (rsp_valid),
      .rsp_result (rsp_result),
      .rsp_err    (rsp_err),
      .busy       (busy),
      .alu        (alu_bus)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;
   int model_ptr = 0;

   bit       stall = 1'b0;
   bit       stray = 1'b0;
   bit       start_seen = 1'b0;
   bit [7:0] seen_a = 8'h0;
   bit [7:0] seen_b = 8'h0;
   bit [2:0] seen_op = 3'h0;

   function automatic logic [15:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                           input logic [2:0] op);
      case (op)
         3'd1:    return 16'(a) + 16'(b);
         3'd2:    return 16'(a & b);
         3'd3:    return 16'(a ^ b);
         default: return 16'h0;
      endcase
   endfunction

   // ALU model: answers one cycle after start unless stalled; stray forces a bogus done.
   always @(negedge clk) begin
      alu_bus.alu_done   = (start_seen && !stall && seen_op != 3'd0) || stray;
      alu_bus.alu_result = stray ? 16'hDEAD : alu_ref(seen_a, seen_b, seen_op);
      start_seen = alu_bus.alu_start;
      seen_a     = alu_bus.alu_a;
      seen_b     = alu_bus.alu_b;
      seen_op    = alu_bus.alu_op;
   end

   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", tag, actual, expected, $time);
      end
   endtask

   task automatic check_all_zero(input string tag);
      checkOutput({tag, "_gnt"}, 32'(gnt), 32'h0);
      checkOutput({tag, "_rsp_valid"}, 32'(rsp_valid), 32'h0);
      checkOutput({tag, "_rsp_result"}, 32'(rsp_result), 32'h0);
      checkOutput({tag, "_rsp_err"}, 32'(rsp_err), 32'h0);
      checkOutput({tag, "_busy"}, 32'(busy), 32'h0);
      checkOutput({tag, "_alu_start"}, 32'(alu_bus.alu_start), 32'h0);
      checkOutput({tag, "_alu_a"}, 32'(alu_bus.alu_a), 32'h0);
      checkOutput({tag, "_alu_b"}, 32'(alu_bus.alu_b), 32'h0);
      checkOutput({tag, "_alu_op"}, 32'(alu_bus.alu_op), 32'h0);
   endtask

   // Called at a negedge with the arbiter idle; returns at the negedge of the next idle cycle.
   task automatic applyStimulus(input logic [NUM_REQ-1:0] rv, input logic [8*NUM_REQ-1:0] av,
                                input logic [8*NUM_REQ-1:0] bv, input logic [3*NUM_REQ-1:0] ov,
                                input bit stall_en, input bit hold_req);
      int win;
      int lat;
      logic [7:0]  wa;
      logic [7:0]  wb;
      logic [2:0]  wop;
      logic [15:0] exp_res;
      logic        exp_err;
      stall  = stall_en;
      req    = rv;
      req_a  = av;
      req_b  = bv;
      req_op = ov;
      win = -1;
      for (int k = 0; k < NUM_REQ; k++) begin
         int j;
         j = (model_ptr + k) % NUM_REQ;
         if (win < 0 && rv[j]) win = j;
      end
      if (win < 0) begin
         @(negedge clk);
         checkOutput("idle_gnt", 32'(gnt), 32'h0);
         checkOutput("idle_busy", 32'(busy), 32'h0);
         checkOutput("idle_rsp", 32'(rsp_valid), 32'h0);
         return;
      end
      wa  = av[win*8 +: 8];
      wb  = bv[win*8 +: 8];
      wop = ov[win*3 +: 3];
      exp_err = (wop == 3'd0) || stall_en;
      exp_res = exp_err ? 16'h0 : alu_ref(wa, wb, wop);
      lat = (wop == 3'd0) ? 2 : (stall_en ? 2 + TIMEOUT : 3);

      @(negedge clk);
      checkOutput("gnt", 32'(gnt), 32'(1) << win);
      checkOutput("alu_start", 32'(alu_bus.alu_start), 32'(wop != 3'd0));
      checkOutput("busy", 32'(busy), 32'h1);
      if (wop != 3'd0) begin
         checkOutput("alu_a", 32'(alu_bus.alu_a), 32'(wa));
         checkOutput("alu_b", 32'(alu_bus.alu_b), 32'(wb));
         checkOutput("alu_op", 32'(alu_bus.alu_op), 32'(wop));
      end
      if (!hold_req) req = NUM_REQ'($urandom);

      for (int c = 2; c <= lat; c++) begin
         @(negedge clk);
         checkOutput("gnt_extra", 32'(gnt), 32'h0);
         if (c == 2) checkOutput("start_extra", 32'(alu_bus.alu_start), 32'h0);
         if (c < lat) begin
            checkOutput("rsp_early", 32'(rsp_valid), 32'h0);
         end else begin
            checkOutput("rsp_valid", 32'(rsp_valid), 32'(1) << win);
            checkOutput("rsp_result", 32'(rsp_result), 32'(exp_res));
            checkOutput("rsp_err", 32'(rsp_err), 32'(exp_err));
         end
      end

      if (!hold_req) req = '0;
      @(negedge clk);
      checkOutput("rsp_after", 32'(rsp_valid), 32'h0);
      checkOutput("rsp_result_idle", 32'(rsp_result), 32'h0);
      checkOutput("busy_idle", 32'(busy), 32'h0);
      model_ptr = (win + 1) % NUM_REQ;
   endtask

   task automatic random_vectors(output logic [8*NUM_REQ-1:0] av, output logic [8*NUM_REQ-1:0] bv,
                                 output logic [3*NUM_REQ-1:0] ov, input bit valid_ops);
      for (int i = 0; i < NUM_REQ; i++) begin
         av[i*8 +: 8] = 8'($urandom_range(0, 255));
         bv[i*8 +: 8] = 8'($urandom_range(0, 255));
         ov[i*3 +: 3] = 3'($urandom_range(valid_ops ? 1 : 0, 3));
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check_all_zero("reset");
      rst = 1'b0;
      model_ptr = 0;
   endtask

   logic [8*NUM_REQ-1:0] av;
   logic [8*NUM_REQ-1:0] bv;
   logic [3*NUM_REQ-1:0] ov;

   initial begin
      rst    = 1'b1;
      req    = '0;
      req_a  = '0;
      req_b  = '0;
      req_op = '0;
      @(negedge clk);
      do_reset();

      // Single request on requester 1: 0x0F + 0x01.
      av = '0; bv = '0; ov = '0;
      av[15:8] = 8'h0F;
      bv[15:8] = 8'h01;
      ov[5:3]  = 3'b001;
      applyStimulus(4'b0010, av, bv, ov, 1'b0, 1'b0);

      // Fairness: all requesters held for 16 operations after reset.
      do_reset();
      for (int n = 0; n < 16; n++) begin
         random_vectors(av, bv, ov, 1'b1);
         applyStimulus(4'b1111, av, bv, ov, 1'b0, 1'b1);
      end

      // Move the pointer to 3, then skip and wrap over 4'b0101.
      random_vectors(av, bv, ov, 1'b1);
      applyStimulus(4'b0100, av, bv, ov, 1'b0, 1'b0);
      for (int n = 0; n < 3; n++) begin
         random_vectors(av, bv, ov, 1'b1);
         applyStimulus(4'b0101, av, bv, ov, 1'b0, 1'b1);
      end

      // Invalid opcode on every requester.
      random_vectors(av, bv, ov, 1'b1);
      ov = '0;
      applyStimulus(4'b0010, av, bv, ov, 1'b0, 1'b0);

      // Timeout with op 010, then stray done pulses while idle.
      random_vectors(av, bv, ov, 1'b1);
      for (int i = 0; i < NUM_REQ; i++) ov[i*3 +: 3] = 3'b010;
      applyStimulus(4'b1000, av, bv, ov, 1'b1, 1'b0);
      stray = 1'b1;
      for (int n = 0; n < 3; n++) applyStimulus('0, av, bv, ov, 1'b0, 1'b0);
      @(negedge clk);
      stray = 1'b0;
      @(negedge clk);
      checkOutput("stray_rsp", 32'(rsp_valid), 32'h0);

      // Random mix of requests, opcodes, stalls and idle gaps.
      for (int n = 0; n < 40; n++) begin
         random_vectors(av, bv, ov, 1'b0);
         applyStimulus(NUM_REQ'($urandom_range(0, (1 << NUM_REQ) - 1)), av, bv, ov,
                       ($urandom_range(0, 7) == 0), $urandom_range(0, 1) == 1);
      end

      // Reset in the middle of WAIT: no response, pointer back to 0.
      random_vectors(av, bv, ov, 1'b1);
      stall  = 1'b1;
      req    = 4'b0100;
      req_a  = av;
      req_b  = bv;
      req_op = ov;
      repeat (3) @(negedge clk);
      checkOutput("mid_busy", 32'(busy), 32'h1);
      req   = '0;
      rst   = 1'b1;
      @(negedge clk);
      check_all_zero("mid_reset");
      rst   = 1'b0;
      stall = 1'b0;
      stray = 1'b1;
      model_ptr = 0;
      for (int n = 0; n < 3; n++) begin
         @(negedge clk);
         checkOutput("post_reset_rsp", 32'(rsp_valid), 32'h0);
         checkOutput("post_reset_busy", 32'(busy), 32'h0);
      end
      stray = 1'b0;
      @(negedge clk);
      random_vectors(av, bv, ov, 1'b1);
      applyStimulus(4'b1111, av, bv, ov, 1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
